fetch_queue: RTL and testbench

- Instruction buffer between the fetch unit and the 4-wide instruction decoder.
- Accepts up to DECODE_NUM 32-bit instructions (with PCs) per cycle from fetch, packs the valid lanes in program order into a circular buffer, and presents the oldest up to DECODE_NUM entries to decode each cycle.
- Decouples fetch bursts from decode/rename stalls.
- Flushed on branch mispredict or exception redirect.

---
 rtl/fetch_queue.sv | 106 ++++++++++
 tb/tb_fetch_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and the decode stage. It compacts the valid
// fetch lanes into a circular buffer and presents the oldest entries to decode.
module fetch_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int DECODE_NUM = 4,
  parameter int DEPTH      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [DECODE_NUM-1:0]            in_valid,
  input  logic [32*DECODE_NUM-1:0]         in_instr,
  input  logic [DATA_WIDTH*DECODE_NUM-1:0] in_pc,
  output logic                             in_ready,
  output logic [DECODE_NUM-1:0]            out_valid,
  output logic [32*DECODE_NUM-1:0]         out_instr,
  output logic [DATA_WIDTH*DECODE_NUM-1:0] out_pc,
  input  logic                             out_ready,
  output logic [$clog2(DEPTH):0]           count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]           instr_q [DEPTH];
  logic [DATA_WIDTH-1:0] pc_q    [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_q;

  logic [PTR_W-1:0] wr_idx [DECODE_NUM];
  logic [CNT_W-1:0] n_in;
  logic [CNT_W-1:0] n_out;
  logic [CNT_W-1:0] enq_add;
  logic [CNT_W-1:0] deq_sub;
  logic             enq_fire;
  logic             deq_fire;

  assign count = count_q;

  // Readiness looks only at registered occupancy, so out_ready never reaches in_ready.
  assign in_ready = (count_q <= CNT_W'(DEPTH - DECODE_NUM));
  assign enq_fire = in_ready && (|in_valid);
  assign deq_fire = out_ready && out_valid[0];

  // Each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    n_in = '0;
    for (int k = 0; k < DECODE_NUM; k++) begin
      wr_idx[k] = tail + n_in[PTR_W-1:0];
      n_in      = n_in + CNT_W'(in_valid[k]);
    end
  end

  always_comb begin
    out_valid = '0;
    for (int k = 0; k < DECODE_NUM; k++) begin
      out_valid[k] = (count_q > CNT_W'(k));
    end
    n_out = (count_q > CNT_W'(DECODE_NUM)) ? CNT_W'(DECODE_NUM) : count_q;
  end

  assign enq_add = enq_fire ? n_in  : '0;
  assign deq_sub = deq_fire ? n_out : '0;

  always_ff @(posedge clk) begin
    if (enq_fire && !flush) begin
      for (int k = 0; k < DECODE_NUM; k++) begin
        if (in_valid[k]) begin
          instr_q[wr_idx[k]] <= in_instr[32*k +: 32];
          pc_q[wr_idx[k]]    <= in_pc[DATA_WIDTH*k +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq_fire) tail <= tail + n_in[PTR_W-1:0];
      if (deq_fire) head <= head + n_out[PTR_W-1:0];
      count_q <= count_q + enq_add - deq_sub;
    end
  end

  // Lanes beyond the current occupancy read as zero rather than stale entries.
  always_comb begin
    out_instr = '0;
    out_pc    = '0;
    for (int k = 0; k < DECODE_NUM; k++) begin
      if (out_valid[k]) begin
        out_instr[32*k +: 32]                 = instr_q[head + PTR_W'(k)];
        out_pc[DATA_WIDTH*k +: DATA_WIDTH]    = pc_q[head + PTR_W'(k)];
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_queue;

  localparam int DW  = 64;
  localparam int DN  = 4;
  localparam int DEP = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [DN-1:0]     in_valid;
  logic [32*DN-1:0]  in_instr;
  logic [DW*DN-1:0]  in_pc;
  logic              in_ready;
  logic [DN-1:0]     out_valid;
  logic [32*DN-1:0]  out_instr;
  logic [DW*DN-1:0]  out_pc;
  logic              out_ready;
  logic [4:0]        count;

  fetch_queue #(.DATA_WIDTH(DW), .DECODE_NUM(DN), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] i;
    logic [63:0] p;
  } ent_t;

  ent_t mq[$];
  int   checks   = 0;
  int   failures = 0;
  logic seq_en   = 1'b0;
  logic [63:0] last_pc;
  int   deq_n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of entries updated at each edge.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
      end else if (flush) begin
        mq.delete();
      end else begin
        automatic bit rdy = (DEP - mq.size()) >= DN;
        if (out_ready && mq.size() > 0) begin
          automatic int n = (mq.size() < DN) ? mq.size() : DN;
          for (int j = 0; j < n; j++) void'(mq.pop_front());
        end
        if (rdy) begin
          for (int k = 0; k < DN; k++) begin
            if (in_valid[k]) begin
              automatic ent_t e;
              e.i = in_instr[32*k +: 32];
              e.p = in_pc[DW*k +: DW];
              mq.push_back(e);
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("count", 64'(count), 64'(mq.size()));
        chk("in_ready", 64'(in_ready), 64'((DEP - mq.size()) >= DN));
        for (int k = 0; k < DN; k++) begin
          automatic bit v = k < mq.size();
          chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(v));
          chk($sformatf("out_instr[%0d]", k), 64'(out_instr[32*k +: 32]), v ? 64'(mq[k].i) : 64'd0);
          chk($sformatf("out_pc[%0d]", k), out_pc[DW*k +: DW], v ? mq[k].p : 64'd0);
        end
        if (seq_en && out_ready && out_valid[0]) begin
          for (int k = 0; k < DN; k++) begin
            if (out_valid[k]) begin
              chk("seq_pc", out_pc[DW*k +: DW], last_pc + 64'd4);
              last_pc = out_pc[DW*k +: DW];
              deq_n++;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DN-1:0] v, input logic [63:0] pc0, input logic [31:0] i0);
    in_valid = v;
    for (int k = 0; k < DN; k++) begin
      in_pc[DW*k +: DW]    = pc0 + 64'(4 * k);
      in_instr[32*k +: 32] = i0 + 32'(k);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = '0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);

    // Full-width enqueue
    drive(4'b1111, 64'h1000, 32'h1100_0000);
    step();
    in_valid = '0;
    chk("t1_out_valid", 64'(out_valid), 64'hF);
    chk("t1_pc0", out_pc[63:0], 64'h1000);
    chk("t1_pc3", out_pc[255:192], 64'h100C);
    chk("t1_count", 64'(count), 64'd4);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Sparse enqueue compacts lanes 1 and 3
    in_valid = 4'b1010;
    in_instr = '0;
    in_instr[63:32]   = 32'hAAAA_0001;
    in_instr[127:96]  = 32'hBBBB_0003;
    in_pc[127:64]     = 64'h2004;
    in_pc[255:192]    = 64'h200C;
    step();
    in_valid = '0;
    chk("t2_out_valid", 64'(out_valid), 64'h3);
    chk("t2_instr0", 64'(out_instr[31:0]), 64'hAAAA_0001);
    chk("t2_instr1", 64'(out_instr[63:32]), 64'hBBBB_0003);
    chk("t2_instr2", 64'(out_instr[95:64]), 64'h0);
    chk("t2_count", 64'(count), 64'd2);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Fill to full, then a burst presented while not ready
    for (int b = 0; b < 4; b++) begin
      drive(4'b1111, 64'h3000 + 64'(16 * b), 32'h3300_0000 + 32'(16 * b));
      step();
    end
    chk("t3_count_full", 64'(count), 64'd16);
    chk("t3_in_ready", 64'(in_ready), 64'd0);
    drive(4'b1111, 64'h9000, 32'h9900_0000);
    step();
    in_valid = '0;
    chk("t3_count_hold", 64'(count), 64'd16);
    chk("t3_pc0_hold", out_pc[63:0], 64'h3000);
    out_ready = 1'b1;
    repeat (4) step();
    out_ready = 1'b0;
    chk("t3_drained", 64'(count), 64'd0);

    // Three-in, four-out streaming across the index wrap
    last_pc = 64'h4000 - 64'd4;
    deq_n   = 0;
    seq_en  = 1'b1;
    begin
      automatic logic [63:0] p = 64'h4000;
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
        automatic logic rdy = in_ready;
        drive(4'b0111, p, 32'h4400_0000 + 32'(c * 3));
        step();
        if (rdy) p = p + 64'd12;
      end
    end
    in_valid = '0;
    repeat (3) step();
    seq_en = 1'b0;
    out_ready = 1'b0;
    chk("t4_deq_total", 64'(deq_n), 64'd30);
    chk("t4_last_pc", last_pc, 64'h4074);

    // Flush beats a simultaneous enqueue and dequeue
    drive(4'b1111, 64'h5000, 32'h5500_0000); step();
    drive(4'b0011, 64'h5010, 32'h5500_0004); step();
    in_valid = '0;
    chk("t5_count6", 64'(count), 64'd6);
    flush = 1'b1; out_ready = 1'b1;
    drive(4'b1111, 64'h5100, 32'h5500_0100);
    step();
    flush = 1'b0; out_ready = 1'b0; in_valid = '0;
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_in_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset between edges
    drive(4'b1111, 64'h6000, 32'h6600_0000); step();
    drive(4'b1111, 64'h6010, 32'h6600_0004); step();
    drive(4'b0001, 64'h6020, 32'h6600_0008); step();
    in_valid = '0;
    chk("t6_count9", 64'(count), 64'd9);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_async_out_valid", 64'(out_valid), 64'd0);
    chk("t6_async_count", 64'(count), 64'd0);
    chk("t6_async_in_ready", 64'(in_ready), 64'd1);
    step();
    rst = 1'b0;
    drive(4'b1111, 64'h7000, 32'h7700_0000);
    step();
    in_valid = '0;
    chk("t6_after_valid", 64'(out_valid), 64'hF);
    chk("t6_after_pc0", out_pc[63:0], 64'h7000);
    chk("t6_after_count", 64'(count), 64'd4);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
